// File: rtl/chrom_pkg.sv
// ============================================================================
// Module   : chrom_pkg
// Brief    : Shared state encoding, register offsets and bit indices for the
//            chromosome serial loader.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package chrom_pkg;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LOAD  = 2'd1;
  localparam logic [1:0] S_SHIFT = 2'd2;

  localparam int CTRL_START = 0;
  localparam int CTRL_ABORT = 1;
  localparam int CTRL_IRQEN = 2;
  localparam int STAT_BUSY  = 0;
  localparam int STAT_DONE  = 1;
  localparam int STAT_PAR   = 2;

  // Control and status sit directly above the segment bank
  function automatic int ctrl_offset(input int num_seg);
    return num_seg;
  endfunction

  function automatic int status_offset(input int num_seg);
    return num_seg + 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/chrom_shift_reg.sv
// ============================================================================
// Module   : chrom_shift_reg
// Brief    : Frame snapshot shifter with beat counter, last flag and parity.
//            CHROM_PARITY_EN appends an even-parity beat after the data bits.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module chrom_shift_reg #(
  parameter int WIDTH = 128
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic             advance,
  input  logic [WIDTH-1:0] par_in,
  output logic             msb,
  output logic             last,
  output logic             parity
);

`ifdef CHROM_PARITY_EN
  localparam int c_frame_w = WIDTH + 1;
`else
  localparam int c_frame_w = WIDTH;
`endif
  localparam int c_cnt_w = $clog2(c_frame_w + 1);

  logic [c_frame_w-1:0] r_shreg;
  logic [c_cnt_w-1:0]   r_count;
  logic                 r_parity;
  logic [c_frame_w-1:0] w_frame;

`ifdef CHROM_PARITY_EN
  assign w_frame = {par_in, ^par_in};
`else
  assign w_frame = par_in;
`endif

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_shreg  <= '0;
      r_count  <= '0;
      r_parity <= 1'b0;
    end else if (load) begin
      r_shreg  <= w_frame;
      r_count  <= c_cnt_w'(c_frame_w - 1);
      r_parity <= ^par_in;
    end else if (advance) begin
      r_shreg <= r_shreg << 1;
      if (r_count != '0) begin
        r_count <= r_count - 1'b1;
      end
    end
  end

  assign msb    = r_shreg[c_frame_w-1];
  assign last   = (r_count == '0);
  assign parity = r_parity;

endmodule

`default_nettype wire

// File: rtl/chrom_serial_loader.sv
// ============================================================================
// Module   : chrom_serial_loader
// Brief    : Avalon-MM chromosome register bank with parallel mirror and a
//            valid/ready serial frame output. Optional macro CHROM_PARITY_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module chrom_serial_loader #(
  parameter int SEG_W   = 32,
  parameter int NUM_SEG = 4,
  parameter int ADDR_W  = 3
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [ADDR_W-1:0]        address,
  input  logic                     chipselect,
  input  logic                     write_n,
  input  logic [31:0]              writedata,
  output logic [31:0]              readdata,
  output logic [NUM_SEG*SEG_W-1:0] out_port,
  output logic                     ser_data,
  output logic                     ser_valid,
  output logic                     ser_last,
  input  logic                     ser_ready,
  output logic                     irq
);

  import chrom_pkg::*;

  localparam int                c_frame_bits = NUM_SEG * SEG_W;
  localparam logic [ADDR_W-1:0] c_ctrl_addr  = ADDR_W'(ctrl_offset(NUM_SEG));
  localparam logic [ADDR_W-1:0] c_stat_addr  = ADDR_W'(status_offset(NUM_SEG));

  logic [SEG_W-1:0]        r_seg [NUM_SEG];
  logic [1:0]              r_state;
  logic [1:0]              w_state_nxt;
  logic                    r_irq_en;
  logic                    r_done;
  logic                    w_wr, w_ctrl_wr, w_stat_wr, w_start, w_abort;
  logic                    w_hs, w_finish, w_load;
  logic                    w_msb, w_last, w_parity, w_par_status;
  logic [c_frame_bits-1:0] w_snapshot;

  assign w_wr      = chipselect & ~write_n;
  assign w_ctrl_wr = w_wr && (address == c_ctrl_addr);
  assign w_stat_wr = w_wr && (address == c_stat_addr);
  assign w_start   = w_ctrl_wr & writedata[CTRL_START];
  assign w_abort   = w_ctrl_wr & writedata[CTRL_ABORT];

  assign ser_valid = (r_state == S_SHIFT);
  assign ser_data  = ser_valid & w_msb;
  assign ser_last  = ser_valid & w_last;
  assign w_hs      = ser_valid & ser_ready;
  assign w_finish  = w_hs & w_last & ~w_abort;
  assign w_load    = (r_state == S_LOAD);
  assign irq       = r_done & r_irq_en;

  // Segment 0 leads the serial frame, so it lands in the snapshot MSBs
  for (genvar k = 0; k < NUM_SEG; k++) begin : g_seg
    assign out_port[k*SEG_W +: SEG_W]                = r_seg[k];
    assign w_snapshot[c_frame_bits-1-k*SEG_W -: SEG_W] = r_seg[k];
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_SEG; i++) begin
        r_seg[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_SEG; i++) begin
        if (w_wr && (address == ADDR_W'(i))) begin
          r_seg[i] <= writedata[SEG_W-1:0];
        end
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_start && !w_abort) w_state_nxt = S_LOAD;
      S_LOAD:  w_state_nxt = w_abort ? S_IDLE : S_SHIFT;
      S_SHIFT: if (w_abort || w_finish) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state  <= S_IDLE;
      r_irq_en <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_ctrl_wr) begin
        r_irq_en <= writedata[CTRL_IRQEN];
      end
      if (w_finish) begin
        r_done <= 1'b1;
      end else if (w_stat_wr && writedata[STAT_DONE]) begin
        r_done <= 1'b0;
      end
    end
  end

`ifdef CHROM_PARITY_EN
  logic r_last_par;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_last_par <= 1'b0;
    end else if (w_finish) begin
      r_last_par <= w_parity;
    end
  end

  assign w_par_status = r_last_par;
`else
  logic w_unused_par;

  assign w_unused_par = w_parity;
  assign w_par_status = 1'b0;
`endif

  always_comb begin
    readdata = '0;
    for (int i = 0; i < NUM_SEG; i++) begin
      if (address == ADDR_W'(i)) begin
        readdata[SEG_W-1:0] = r_seg[i];
      end
    end
    if (address == c_ctrl_addr) begin
      readdata[CTRL_IRQEN] = r_irq_en;
    end
    if (address == c_stat_addr) begin
      readdata[STAT_BUSY] = (r_state != S_IDLE);
      readdata[STAT_DONE] = r_done;
      readdata[STAT_PAR]  = w_par_status;
    end
  end

  chrom_shift_reg #(
    .WIDTH (c_frame_bits)
  ) u_shift (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (w_load),
    .advance (w_hs),
    .par_in  (w_snapshot),
    .msb     (w_msb),
    .last    (w_last),
    .parity  (w_parity)
  );

endmodule

`default_nettype wire

// File: tb/tb_chrom_serial_loader.sv
// ============================================================================
// Module   : tb_chrom_serial_loader
// Brief    : Scoreboard bench for chrom_serial_loader (default parameters).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_chrom_serial_loader;

  localparam int ADDR_W = 3;
  localparam int CTRL   = 4;
  localparam int STAT   = 5;
`ifdef CHROM_PARITY_EN
  localparam bit PAR   = 1'b1;
  localparam int FRAME = 129;
`else
  localparam bit PAR   = 1'b0;
  localparam int FRAME = 128;
`endif

  logic              clk = 1'b0;
  logic              reset_n;
  logic [ADDR_W-1:0] address;
  logic              chipselect;
  logic              write_n;
  logic [31:0]       writedata;
  logic [31:0]       readdata;
  logic [127:0]      out_port;
  logic              ser_data, ser_valid, ser_last, ser_ready;
  logic              irq;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [1:0]  exp_q [$];
  logic [31:0] m_seg [4];
  int          beats = 0;
  int          valid_cycles = 0;
  logic        toggle_en = 1'b0;
  logic        was_stalled = 1'b0;
  logic        held_data, held_last;
  logic        frame_par, done_par;

  always #5 clk = ~clk;

  chrom_serial_loader #(.SEG_W(32), .NUM_SEG(4), .ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .out_port   (out_port),
    .ser_data   (ser_data),
    .ser_valid  (ser_valid),
    .ser_last   (ser_last),
    .ser_ready  (ser_ready),
    .irq        (irq)
  );

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] stat_val(input logic busy, input logic done, input logic par);
    return {29'b0, PAR ? par : 1'b0, done, busy};
  endfunction

  // Monitor: pops the scoreboard on each accepted beat and checks stall hold
  always @(negedge clk) begin : mon
    logic [1:0] e;
    if (ser_valid) valid_cycles++;
    if (ser_valid && was_stalled) begin
      check("stall_data", ser_data, held_data);
      check("stall_last", ser_last, held_last);
    end
    if (ser_valid && !ser_ready) begin
      was_stalled = 1'b1;
      held_data   = ser_data;
      held_last   = ser_last;
    end else begin
      was_stalled = 1'b0;
    end
    if (ser_valid && ser_ready) begin
      beats++;
      if (exp_q.size() == 0) begin
        check("unexpected_beat", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check("beat_data", ser_data, e[1]);
        check("beat_last", ser_last, e[0]);
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (toggle_en) ser_ready = ~ser_ready;
    end
  end

  task automatic avalon_write(input int addr, input logic [31:0] data);
    @(posedge clk);
    #1;
    address    = ADDR_W'(addr);
    writedata  = data;
    chipselect = 1'b1;
    write_n    = 1'b0;
    if (addr < 4) m_seg[addr] = data;
    @(posedge clk);
    #1;
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic read_check(input string name, input int addr, input logic [31:0] exp);
    @(posedge clk);
    #1;
    address    = ADDR_W'(addr);
    chipselect = 1'b1;
    #2;
    check(name, readdata, exp);
    chipselect = 1'b0;
  endtask

  task automatic push_frame();
    logic [127:0] fr;
    fr = {m_seg[0], m_seg[1], m_seg[2], m_seg[3]};
    frame_par = ^fr;
    for (int i = 127; i >= 0; i--) exp_q.push_back({fr[i], (i == 0) && !PAR});
    if (PAR) exp_q.push_back({frame_par, 1'b1});
  endtask

  task automatic wait_frame(input string name, input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || ser_valid) && n < budget) begin
      @(posedge clk);
      #1;
      n++;
    end
    check(name, (exp_q.size() == 0 && !ser_valid), 1);
  endtask

  initial begin
    reset_n = 1'b0; ser_ready = 1'b0; chipselect = 1'b0; write_n = 1'b1;
    address = '0; writedata = '0; done_par = 1'b0;
    for (int i = 0; i < 4; i++) m_seg[i] = '0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;

    // Reset state
    for (int a = 0; a < 8; a++) read_check($sformatf("reset_rd%0d", a), a, 32'h0);
    check("reset_out_port", out_port, 128'h0);
    check("reset_ser_valid", ser_valid, 0);
    check("reset_irq", irq, 0);

    // Register bank and parallel mirror
    avalon_write(0, 32'hA5A5A5A5);
    avalon_write(3, 32'h00000001);
    avalon_write(7, 32'hFFFFFFFF);
    read_check("rd_seg0", 0, 32'hA5A5A5A5);
    read_check("rd_seg3", 3, 32'h00000001);
    read_check("rd_seg1", 1, 32'h0);
    read_check("rd_unmapped", 7, 32'h0);
    check("out_port_seg3", out_port[127:96], 32'h00000001);
    check("out_port_seg0", out_port[31:0], 32'hA5A5A5A5);

    // Full-rate frame and start latency
    ser_ready = 1'b1;
    valid_cycles = 0; beats = 0;
    push_frame();
    avalon_write(CTRL, 32'h1);
    check("lat_load_cycle", ser_valid, 0);
    @(posedge clk);
    #1;
    check("lat_shift_cycle", ser_valid, 1);
    wait_frame("frame1_done", 400);
    done_par = frame_par;
    check("frame1_beats", beats, FRAME);
    check("frame1_cycles", valid_cycles, FRAME);
    read_check("frame1_status", STAT, stat_val(0, 1, done_par));
    avalon_write(STAT, 32'h2);
    read_check("done_cleared", STAT, stat_val(0, 0, done_par));

    // Throttled consumer, ignored START and segment write during a frame
    valid_cycles = 0; beats = 0;
    toggle_en = 1'b1;
    push_frame();
    avalon_write(CTRL, 32'h1);
    repeat (5) @(posedge clk);
    read_check("busy_status", STAT, stat_val(1, 0, done_par));
    avalon_write(CTRL, 32'h1);
    avalon_write(1, 32'hFFFF0000);
    check("live_out_port_seg1", out_port[63:32], 32'hFFFF0000);
    wait_frame("frame2_done", 800);
    done_par = frame_par;
    toggle_en = 1'b0;
    ser_ready = 1'b1;
    check("frame2_beats", beats, FRAME);
    check("frame2_cycles", (valid_cycles >= 2*FRAME-1) && (valid_cycles <= 2*FRAME), 1);
    repeat (5) @(posedge clk);
    #1;
    check("no_second_frame", ser_valid, 0);
    read_check("frame2_status", STAT, stat_val(0, 1, done_par));
    avalon_write(STAT, 32'h2);

    // Abort at beat 40, then full replay
    beats = 0;
    push_frame();
    avalon_write(CTRL, 32'h1);
    for (int n = 0; n < 200 && beats < 39; n++) begin
      @(posedge clk);
      #1;
    end
    ser_ready = 1'b0;
    avalon_write(CTRL, 32'h2);
    check("abort_valid_drop", ser_valid, 0);
    check("abort_beats", beats, 39);
    exp_q.delete();
    read_check("abort_status", STAT, stat_val(0, 0, done_par));
    ser_ready = 1'b1;
    beats = 0;
    push_frame();
    avalon_write(CTRL, 32'h1);
    wait_frame("replay_done", 400);
    done_par = frame_par;
    check("replay_beats", beats, FRAME);
    avalon_write(STAT, 32'h2);

    // START together with ABORT starts nothing
    avalon_write(CTRL, 32'h3);
    repeat (3) @(posedge clk);
    #1;
    check("start_abort_valid", ser_valid, 0);
    read_check("start_abort_status", STAT, stat_val(0, 0, done_par));

    // Interrupt and parity frame
    avalon_write(0, 32'h1);
    avalon_write(1, 32'h0);
    avalon_write(2, 32'h0);
    avalon_write(3, 32'h0);
    avalon_write(CTRL, 32'h4);
    read_check("ctrl_irqen", CTRL, 32'h4);
    check("irq_idle", irq, 0);
    beats = 0;
    push_frame();
    avalon_write(CTRL, 32'h5);
    wait_frame("irq_frame_done", 400);
    done_par = frame_par;
    check("irq_frame_beats", beats, FRAME);
    check("irq_set", irq, 1);
    read_check("par_status", STAT, stat_val(0, 1, 1'b1));
    avalon_write(STAT, 32'h2);
    check("irq_cleared", irq, 0);
    read_check("par_status_cleared", STAT, stat_val(0, 0, 1'b1));

    // Reset in the middle of a frame
    push_frame();
    avalon_write(CTRL, 32'h5);
    repeat (10) @(posedge clk);
    #1 reset_n = 1'b0;
    @(posedge clk);
    #1;
    check("midreset_valid", ser_valid, 0);
    check("midreset_out_port", out_port, 128'h0);
    exp_q.delete();
    reset_n = 1'b1;
    read_check("midreset_ctrl", CTRL, 32'h0);
    read_check("midreset_status", STAT, 32'h0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
